// File: rtl/axi4_lite_regfile.sv
// AXI4-Lite slave register file: NUM_REGS x DATA_WIDTH, byte-lane writes, DECERR decode.
// Optional privilege check on awprot[0]/arprot[0] with `define AXI4_REGFILE_PRIV_EN.
package axi4;
  typedef logic [2:0] prot_t;
  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_t;
endpackage

module axi4_lite_regfile #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 12,
  parameter int NUM_REGS   = 16
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [ADDR_WIDTH-1:0]          awaddr,
  input  axi4::prot_t                    awprot,
  input  logic                           awvalid,
  output logic                           awready,
  input  logic [DATA_WIDTH-1:0]          wdata,
  input  logic [DATA_WIDTH/8-1:0]        wstrb,
  input  logic                           wvalid,
  output logic                           wready,
  output axi4::resp_t                    bresp,
  output logic                           bvalid,
  input  logic                           bready,
  input  logic [ADDR_WIDTH-1:0]          araddr,
  input  axi4::prot_t                    arprot,
  input  logic                           arvalid,
  output logic                           arready,
  output logic [DATA_WIDTH-1:0]          rdata,
  output axi4::resp_t                    rresp,
  output logic                           rvalid,
  input  logic                           rready,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
  output logic [NUM_REGS-1:0]            wr_pulse
);

  localparam int NB   = DATA_WIDTH / 8;
  localparam int LSB  = $clog2(NB);
  localparam int IDXW = $clog2(NUM_REGS);
  localparam int HI   = LSB + IDXW;

  typedef enum logic {W_IDLE, W_RESP} wst_t;
  typedef enum logic {R_IDLE, R_RESP} rst_t;

  logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];
  logic [NUM_REGS-1:0]   r_wr_pulse;

  // DECERR outranks the privilege check
  function automatic axi4::resp_t f_resp(
    input logic [ADDR_WIDTH-1:0] a,
    input logic                  priv_ok
  );
    if ((a >> HI) != '0) return axi4::DECERR;
    if (!priv_ok)        return axi4::SLVERR;
    return axi4::OKAY;
  endfunction

  // ---------------- write path ----------------
  wst_t                  r_wst, w_wst_nxt;
  logic                  r_aw_held, r_w_held;
  logic [ADDR_WIDTH-1:0] r_awaddr;
  axi4::prot_t           r_awprot;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [NB-1:0]         r_wstrb;
  axi4::resp_t           r_bresp;

  logic                  w_aw_hs, w_w_hs, w_commit, w_aw_priv;
  logic [ADDR_WIDTH-1:0] w_waddr;
  axi4::prot_t           w_wprot;
  logic [DATA_WIDTH-1:0] w_wd;
  logic [NB-1:0]         w_ws;
  logic [IDXW-1:0]       w_widx;
  axi4::resp_t           w_wresp;

  assign w_aw_hs  = awvalid && awready;
  assign w_w_hs   = wvalid && wready;
  assign w_waddr  = r_aw_held ? r_awaddr : awaddr;
  assign w_wprot  = r_aw_held ? r_awprot : awprot;
  assign w_wd     = r_w_held ? r_wdata : wdata;
  assign w_ws     = r_w_held ? r_wstrb : wstrb;
  assign w_widx   = w_waddr[LSB +: IDXW];
  assign w_commit = (r_wst == W_IDLE)
                 && (r_aw_held || w_aw_hs)
                 && (r_w_held || w_w_hs);
`ifdef AXI4_REGFILE_PRIV_EN
  assign w_aw_priv = w_wprot[0];
`else
  assign w_aw_priv = 1'b1;
`endif
  assign w_wresp  = f_resp(w_waddr, w_aw_priv);

  always_ff @(posedge clock) begin
    if (reset) r_wst <= W_IDLE;
    else       r_wst <= w_wst_nxt;
  end

  always_comb begin
    w_wst_nxt = r_wst;
    unique case (r_wst)
      W_IDLE: if (w_commit) w_wst_nxt = W_RESP;
      W_RESP: if (bready)   w_wst_nxt = W_IDLE;
      default:              w_wst_nxt = W_IDLE;
    endcase
  end

  always_comb begin
    awready = 1'b0;
    wready  = 1'b0;
    bvalid  = 1'b0;
    unique case (r_wst)
      W_IDLE: begin
        awready = !r_aw_held && !reset;
        wready  = !r_w_held && !reset;
      end
      W_RESP:  bvalid = 1'b1;
      default: bvalid = 1'b0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_aw_held  <= 1'b0;
      r_w_held   <= 1'b0;
      r_awaddr   <= '0;
      r_awprot   <= '0;
      r_wdata    <= '0;
      r_wstrb    <= '0;
      r_bresp    <= axi4::OKAY;
      r_wr_pulse <= '0;
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else begin
      r_wr_pulse <= '0;
      if (w_aw_hs) begin
        r_aw_held <= 1'b1;
        r_awaddr  <= awaddr;
        r_awprot  <= awprot;
      end
      if (w_w_hs) begin
        r_w_held <= 1'b1;
        r_wdata  <= wdata;
        r_wstrb  <= wstrb;
      end
      if (bvalid && bready) begin
        r_aw_held <= 1'b0;
        r_w_held  <= 1'b0;
      end
      if (w_commit) begin
        r_bresp <= w_wresp;
        if (w_wresp == axi4::OKAY) begin
          r_wr_pulse[w_widx] <= 1'b1;
          for (int k = 0; k < NB; k++)
            if (w_ws[k]) r_regs[w_widx][8*k +: 8] <= w_wd[8*k +: 8];
        end
      end
    end
  end

  assign bresp    = r_bresp;
  assign wr_pulse = r_wr_pulse;

  // ---------------- read path ----------------
  rst_t                  r_rst, w_rst_nxt;
  logic [DATA_WIDTH-1:0] r_rdata;
  axi4::resp_t           r_rresp;
  logic                  w_ar_hs, w_ar_priv;
  axi4::resp_t           w_rresp;

  assign w_ar_hs = arvalid && arready;
`ifdef AXI4_REGFILE_PRIV_EN
  assign w_ar_priv = arprot[0];
`else
  assign w_ar_priv = 1'b1;
`endif
  assign w_rresp = f_resp(araddr, w_ar_priv);

  always_ff @(posedge clock) begin
    if (reset) r_rst <= R_IDLE;
    else       r_rst <= w_rst_nxt;
  end

  always_comb begin
    w_rst_nxt = r_rst;
    unique case (r_rst)
      R_IDLE: if (w_ar_hs) w_rst_nxt = R_RESP;
      R_RESP: if (rready)  w_rst_nxt = R_IDLE;
      default:             w_rst_nxt = R_IDLE;
    endcase
  end

  always_comb begin
    arready = 1'b0;
    rvalid  = 1'b0;
    unique case (r_rst)
      R_IDLE:  arready = !reset;
      R_RESP:  rvalid  = 1'b1;
      default: rvalid  = 1'b0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_rdata <= '0;
      r_rresp <= axi4::OKAY;
    end else if (w_ar_hs) begin
      r_rresp <= w_rresp;
      r_rdata <= (w_rresp == axi4::OKAY)
               ? r_regs[araddr[LSB +: IDXW]] : '0;
    end
  end

  assign rdata = r_rdata;
  assign rresp = r_rresp;

  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_q
    assign reg_q[gi*DATA_WIDTH +: DATA_WIDTH] = r_regs[gi];
  end

  // byte-offset bits and unused prot bits are don't-care by design
  logic w_unused;
  assign w_unused = ^{w_waddr[LSB-1:0], araddr[LSB-1:0], w_wprot, arprot};

endmodule
